// File: rtl/spi_master_ctrl.sv
// SPI master sequencing 10-bit command frames (2-bit op + 8-bit payload) to the SPI RAM slave.
// Optional SPI_CTRL_AUTO_RD_EN: an op-10 command also runs the op-11 read-data frame.
module spi_master_ctrl #(
    parameter int RD_GAP   = 1,
    parameter int IDLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS_n
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHK   = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] RECV  = 3'd4;
    localparam logic [2:0] TAIL  = 3'd5;

    localparam logic [3:0] GAP_LAST  = 4'(RD_GAP - 1);
    localparam logic [3:0] TAIL_LAST = 4'(IDLE_CYC - 1);
    localparam logic [9:0] RD_FRAME  = {2'b11, 8'h00};

    logic [2:0] st, st_n;
    logic [3:0] cnt, cnt_n;
    logic [9:0] frame, frame_n;
    logic [6:0] cap;
    logic       accept;
    logic       rd_end;
    logic       sel_n;
    logic       mosi_n;

`ifdef SPI_CTRL_AUTO_RD_EN
    logic auto, auto_n;
`endif

    assign cmd_ready = (st == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign rd_end    = (st == RECV) && (cnt == 4'd0);

    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        frame_n = frame;
`ifdef SPI_CTRL_AUTO_RD_EN
        auto_n  = auto;
`endif
        case (st)
            IDLE: begin
                if (accept) begin
                    st_n    = CHK;
                    frame_n = (cmd_op == 2'b11) ? RD_FRAME : {cmd_op, cmd_data};
`ifdef SPI_CTRL_AUTO_RD_EN
                    auto_n  = (cmd_op == 2'b10);
`endif
                end
            end
            CHK: begin
                st_n  = SHIFT;
                cnt_n = 4'd9;
            end
            SHIFT: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else if (frame[9:8] != 2'b11) begin
                    st_n  = TAIL;
                    cnt_n = TAIL_LAST;
                end else if (RD_GAP == 0) begin
                    st_n  = RECV;
                    cnt_n = 4'd7;
                end else begin
                    st_n  = GAP;
                    cnt_n = GAP_LAST;
                end
            end
            GAP: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    st_n  = RECV;
                    cnt_n = 4'd7;
                end
            end
            RECV: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    st_n  = TAIL;
                    cnt_n = TAIL_LAST;
                end
            end
            TAIL: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    st_n = IDLE;
`ifdef SPI_CTRL_AUTO_RD_EN
                    // chained read-data frame after the rd-addr tail
                    if (auto) begin
                        st_n    = CHK;
                        frame_n = RD_FRAME;
                        auto_n  = 1'b0;
                    end
`endif
                end
            end
            default: st_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        sel_n  = (st_n == CHK) || (st_n == SHIFT) ||
                 (st_n == GAP) || (st_n == RECV);
        mosi_n = 1'b0;
        if (st_n == CHK) begin
            mosi_n = frame_n[9];
        end else if (st_n == SHIFT) begin
            mosi_n = frame_n[cnt_n];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            cnt       <= 4'd0;
            frame     <= 10'd0;
            cap       <= 7'd0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
`ifdef SPI_CTRL_AUTO_RD_EN
            auto      <= 1'b0;
`endif
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            frame     <= frame_n;
            SS_n      <= !sel_n;
            MOSI      <= mosi_n;
            busy      <= (st_n != IDLE);
            rsp_valid <= rd_end;
`ifdef SPI_CTRL_AUTO_RD_EN
            auto      <= auto_n;
`endif
            if (st == RECV) begin
                cap <= {cap[5:0], MISO};
            end
            if (rd_end) begin
                rsp_data <= {cap, MISO};
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI RAM slave.
// Expected values are hand-derived frame images and timings.
module tb_spi_master_ctrl;

    localparam int RG = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       MOSI;
    logic       MISO;
    logic       SS_n;

    always #5 clk = ~clk;

    spi_master_ctrl #(
        .RD_GAP  (RG),
        .IDLE_CYC(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .busy     (busy),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .SS_n     (SS_n)
    );

    // slave RAM model: k is the cycle index inside the SS_n-low window
    bit   [7:0] mem [256];
    logic [7:0] wa = 8'h00;
    logic [7:0] ra = 8'h00;
    logic [7:0] tx = 8'h00;
    logic [9:0] sh = 10'd0;
    int         k = 0;

    always @(negedge clk) begin
        if (SS_n) begin
            k    <= 0;
            MISO <= 1'b1;
        end else begin
            k <= k + 1;
            if (k >= 1 && k <= 10) sh <= {sh[8:0], MOSI};
            if (k == 10) begin
                case (sh[8:7])
                    2'b00:   wa <= {sh[6:0], MOSI};
                    2'b01:   mem[wa] <= {sh[6:0], MOSI};
                    2'b10:   ra <= {sh[6:0], MOSI};
                    default: tx <= mem[ra];
                endcase
            end
            if (k >= 11 + RG && k <= 18 + RG) MISO <= tx[3'(18 + RG - k)];
            else MISO <= 1'b1;
        end
    end

    int nchk = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int          nfr, nacc, nrsp, rsp_at, gap, tailc;
    int          lowl [3];
    logic [31:0] mseq [3];
    logic [7:0]  rspd;
    logic        rdy_bad, mosi_bad;

    task automatic observe(input int n, input int hold_at,
                           input logic [1:0] hop, input logic [7:0] hdat);
        logic        prev;
        int          len;
        logic [31:0] seq;
        nfr = 0; nacc = 0; nrsp = 0; rsp_at = -1; gap = 0; tailc = 0;
        rspd = 8'h00; rdy_bad = 1'b0; mosi_bad = 1'b0;
        lowl = '{default: 0};
        mseq = '{default: 32'h0};
        prev = 1'b1; len = 0; seq = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (cmd_valid && cmd_ready) begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                nacc++;
            end
            @(negedge clk);
            if (!SS_n) begin
                if (prev) begin
                    nfr++;
                    len = 0;
                    seq = 32'h0;
                end
                len++;
                seq = {seq[30:0], MOSI};
                if (nfr >= 1 && nfr <= 3) begin
                    lowl[nfr-1] = len;
                    mseq[nfr-1] = seq;
                end
            end else begin
                if (nfr == 1) gap++;
                if (busy) tailc++;
                if (MOSI) mosi_bad = 1'b1;
            end
            if (busy && cmd_ready) rdy_bad = 1'b1;
            if (rsp_valid) begin
                nrsp++;
                rspd = rsp_data;
                rsp_at = i;
            end
            if (i == hold_at) begin
                cmd_valid = 1'b1;
                cmd_op = hop;
                cmd_data = hdat;
            end
            prev = SS_n;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = d;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ss", SS_n, 1);
        check("rst_mosi", MOSI, 0);
        check("rst_rv", rsp_valid, 0);
        check("rst_rd", rsp_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_rdy", cmd_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b00, 8'hCC);
        observe(14, -1, 2'b00, 8'h00);
        check("wa_acc", nacc, 1);
        check("wa_nfr", nfr, 1);
        check("wa_len", lowl[0], 11);
        check("wa_mosi", mseq[0], 32'h0CC);
        check("wa_tail", tailc, 1);
        check("wa_rsp", nrsp, 0);
        check("wa_busy", busy, 0);
        check("wa_rdy", cmd_ready, 1);
        check("wa_mhi", mosi_bad, 0);

        issue(2'b01, 8'hCC);
        observe(50, 0, 2'b10, 8'hCC);
        check("b2b_acc", nacc, 2);
        check("b2b_len0", lowl[0], 11);
        check("b2b_len1", lowl[1], 11);
        check("b2b_gap", gap, 2);
        check("b2b_mosi0", mseq[0], 32'h1CC);
        check("b2b_mosi1", mseq[1], 32'h6CC);
        check("b2b_rdy", rdy_bad, 0);
`ifdef SPI_CTRL_AUTO_RD_EN
        check("b2b_nfr", nfr, 3);
        check("b2b_len2", lowl[2], 20);
        check("b2b_mosi2", mseq[2], 32'hE0000);
        check("b2b_rsp", nrsp, 1);
        check("b2b_rspd", rspd, 8'hCC);
`else
        check("b2b_nfr", nfr, 2);
        check("b2b_rsp", nrsp, 0);
`endif

        issue(2'b11, 8'hFF);
        observe(25, -1, 2'b00, 8'h00);
        check("rd_nfr", nfr, 1);
        check("rd_len", lowl[0], 20);
        check("rd_mosi", mseq[0], 32'hE0000);
        check("rd_nrsp", nrsp, 1);
        check("rd_rspd", rspd, 8'hCC);
        check("rd_at", rsp_at, 20);
        check("rd_hold", rsp_data, 8'hCC);
        check("rd_mhi", mosi_bad, 0);

        issue(2'b00, 8'hCC);
        observe(30, 4, 2'b01, 8'h55);
        check("hold_acc", nacc, 2);
        check("hold_nfr", nfr, 2);
        check("hold_len", lowl[1], 11);
        check("hold_mosi", mseq[1], 32'h155);
        check("hold_gap", gap, 2);
        check("hold_rdy", rdy_bad, 0);

        issue(2'b00, 8'h3A);
        observe(14, -1, 2'b00, 8'h00);
        issue(2'b01, 8'hA5);
        observe(14, -1, 2'b00, 8'h00);
        issue(2'b10, 8'h3A);
`ifdef SPI_CTRL_AUTO_RD_EN
        observe(40, -1, 2'b00, 8'h00);
        check("auto_nfr", nfr, 2);
        check("auto_acc", nacc, 1);
        check("auto_len1", lowl[1], 20);
        check("auto_nrsp", nrsp, 1);
        check("auto_rspd", rspd, 8'hA5);
        check("auto_rdy", rdy_bad, 0);
`else
        observe(14, -1, 2'b00, 8'h00);
        check("ra_nrsp", nrsp, 0);
        check("ra_mosi", mseq[0], 32'h63A);
        issue(2'b11, 8'h00);
        observe(25, -1, 2'b00, 8'h00);
        check("loop_nrsp", nrsp, 1);
        check("loop_rspd", rspd, 8'hA5);
`endif

        issue(2'b11, 8'h00);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_ss", SS_n, 0);
        rst_n = 1'b0;
        #1;
        check("arst_ss", SS_n, 1);
        check("arst_mosi", MOSI, 0);
        check("arst_rd", rsp_data, 8'h00);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        observe(25, -1, 2'b00, 8'h00);
        check("post_nfr", nfr, 0);
        check("post_rsp", nrsp, 0);
        issue(2'b00, 8'h5A);
        observe(14, -1, 2'b00, 8'h00);
        check("post_len", lowl[0], 11);
        check("post_mosi", mseq[0], 32'h05A);
        check("post_nfr2", nfr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
